// File: rtl/or_gate.sv
// Bitwise OR with a combinational output and a registered, valid-qualified copy.
// Also keeps a saturating count of accepted samples whose result is nonzero.
module or_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] C_q,
  output logic             out_valid,
  output logic             any_q,
  output logic [CNT_W-1:0] act_cnt,
  output logic             cnt_sat
);

  logic [WIDTH-1:0] w_orResult;
  logic             w_anySet;
  logic             w_countUp;

  logic [WIDTH-1:0] r_resultQ;
  logic             r_anyQ;
  logic             r_validQ;
  logic [CNT_W-1:0] r_actCnt;

  assign w_orResult = A | B;
  assign w_anySet   = |w_orResult;

  // The counter stops at all-ones instead of wrapping.
  assign cnt_sat   = &r_actCnt;
  assign w_countUp = in_valid && w_anySet && !cnt_sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_resultQ <= '0;
      r_anyQ    <= 1'b0;
      r_validQ  <= 1'b0;
      r_actCnt  <= '0;
    end else begin
      if (in_valid) begin
        r_resultQ <= w_orResult;
        r_anyQ    <= w_anySet;
      end
      r_validQ <= in_valid;
      // A clear wins over a same-cycle increment.
      if (clr_cnt) begin
        r_actCnt <= '0;
      end else if (w_countUp) begin
        r_actCnt <= r_actCnt + CNT_W'(1);
      end
    end
  end

  assign C         = w_orResult;
  assign C_q       = r_resultQ;
  assign out_valid = r_validQ;
  assign any_q     = r_anyQ;
  assign act_cnt   = r_actCnt;

endmodule

// File: tb/tb_or_gate.sv
// Self-checking bench for or_gate: a 1-bit instance for the truth table and an
// 8-bit instance with a 4-bit counter for the registered path and saturation.
module tb_or_gate;

  logic       clk;
  logic       rst;

  logic       a1, b1, v1, clr1;
  logic       c1, cq1, ov1, any1, sat1;
  logic [15:0] cnt1;

  logic [7:0] a8, b8;
  logic       v8, clr8;
  logic [7:0] c8, cq8;
  logic       ov8, any8, sat8;
  logic [3:0] cnt8;

  int nChecks;
  int nFail;

  typedef struct {
    logic [7:0] cq;
    logic       anyBit;
    logic       ov;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb[$];

  logic [7:0] mCq;
  logic       mAny;
  logic       mOv;
  int         mCnt;

  or_gate #(.WIDTH(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .in_valid(v1), .clr_cnt(clr1),
    .C(c1), .C_q(cq1), .out_valid(ov1), .any_q(any1), .act_cnt(cnt1), .cnt_sat(sat1)
  );

  or_gate #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .in_valid(v8), .clr_cnt(clr8),
    .C(c8), .C_q(cq8), .out_valid(ov8), .any_q(any8), .act_cnt(cnt8), .cnt_sat(sat8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle on the 8-bit instance, push the expected post-edge state,
  // and return 1 ns after the capturing edge with the inputs still held.
  task automatic cycle(input logic [7:0] a, input logic [7:0] b,
                       input logic v, input logic clr, input logic r);
    exp_t e;
    a8 = a; b8 = b; v8 = v; clr8 = clr; rst = r;
    if (r) begin
      mCq = '0; mAny = 1'b0; mOv = 1'b0; mCnt = 0;
    end else begin
      if (v) begin
        mCq  = a | b;
        mAny = ((a | b) != 8'h00);
      end
      mOv = v;
      if (clr) mCnt = 0;
      else if (v && ((a | b) != 8'h00) && mCnt < 15) mCnt = mCnt + 1;
    end
    e.cq = mCq; e.anyBit = mAny; e.ov = mOv; e.cnt = 4'(mCnt);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    cycle(8'h30, 8'h03, 1'b1, 1'b0, 1'b1);
    void'(sb.pop_front());
    cycle(8'h30, 8'h03, 1'b1, 1'b0, 1'b1);
    e = sb.pop_front();
    nChecks++;
    if (cq8 !== e.cq || any8 !== e.anyBit || ov8 !== e.ov || cnt8 !== e.cnt || sat8 !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL reset_state: C_q=%h any=%b ov=%b cnt=%0d sat=%b, required %h %b %b %0d 0",
               cq8, any8, ov8, cnt8, sat8, e.cq, e.anyBit, e.ov, e.cnt);
    end
    nChecks++;
    if (c8 !== 8'h33) begin
      nFail++;
      $display("[TB] FAIL c_during_reset: C=%h, required 33", c8);
    end
  endtask

  task automatic test_truth_table();
    logic [3:0] want;
    want = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      a1 = i[1]; b1 = i[0];
      #5;
      nChecks++;
      if (c1 !== want[i]) begin
        nFail++;
        $display("[TB] FAIL truth_table_%0d%0d: C=%b, required %b", i[1], i[0], c1, want[i]);
      end
      #5;
    end
    nChecks++;
    if (cq1 !== 1'b0 || ov1 !== 1'b0 || any1 !== 1'b0 || cnt1 !== 16'd0 || sat1 !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL idle_1bit_regs: C_q=%b ov=%b any=%b cnt=%0d sat=%b, required all 0",
               cq1, ov1, any1, cnt1, sat1);
    end
  endtask

  task automatic test_first_sample();
    exp_t e;
    cycle(8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
    e = sb.pop_front();
    nChecks++;
    if (cq8 !== e.cq || any8 !== e.anyBit || ov8 !== e.ov || cnt8 !== e.cnt) begin
      nFail++;
      $display("[TB] FAIL first_sample: C_q=%h any=%b ov=%b cnt=%0d, required %h %b %b %0d",
               cq8, any8, ov8, cnt8, e.cq, e.anyBit, e.ov, e.cnt);
    end
  endtask

  task automatic test_zero_and_hold();
    exp_t e;
    cycle(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    e = sb.pop_front();
    nChecks++;
    if (cq8 !== e.cq || any8 !== e.anyBit || ov8 !== e.ov || cnt8 !== e.cnt) begin
      nFail++;
      $display("[TB] FAIL zero_sample: C_q=%h any=%b ov=%b cnt=%0d, required %h %b %b %0d",
               cq8, any8, ov8, cnt8, e.cq, e.anyBit, e.ov, e.cnt);
    end
    cycle(8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    nChecks++;
    if (cq8 !== e.cq || ov8 !== e.ov || cnt8 !== e.cnt || c8 !== 8'h01) begin
      nFail++;
      $display("[TB] FAIL hold_invalid: C_q=%h ov=%b cnt=%0d C=%h, required %h %b %0d 01",
               cq8, ov8, cnt8, c8, e.cq, e.ov, e.cnt);
    end
  endtask

  task automatic test_wide_or();
    exp_t e;
    a8 = 8'hA0; b8 = 8'h05; v8 = 1'b1;
    #1;
    nChecks++;
    if (c8 !== 8'hA5) begin
      nFail++;
      $display("[TB] FAIL wide_c_comb: C=%h, required a5", c8);
    end
    @(posedge clk);
    #1;
    cycle(8'hA0, 8'h05, 1'b1, 1'b0, 1'b0);
    void'(sb.pop_front());
    cycle(8'h3C, 8'h00, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    nChecks++;
    if (cq8 !== 8'hA5 || cq8 !== e.cq || any8 !== e.anyBit || ov8 !== e.ov) begin
      nFail++;
      $display("[TB] FAIL wide_c_q_hold: C_q=%h any=%b ov=%b, required a5 %b %b",
               cq8, any8, ov8, e.anyBit, e.ov);
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    // The un-modelled edge above already counted one sample; resync the model.
    mCnt = mCnt + 1;
    for (int i = 0; i < 20; i++) begin
      cycle(8'(i + 1), 8'h00, 1'b1, 1'b0, 1'b0);
      e = sb.pop_front();
      nChecks++;
      if (cnt8 !== e.cnt || sat8 !== (e.cnt == 4'hF)) begin
        nFail++;
        $display("[TB] FAIL sat_count_%0d: cnt=%0d sat=%b, required %0d %b",
                 i, cnt8, sat8, e.cnt, (e.cnt == 4'hF));
      end
    end
    nChecks++;
    if (cnt8 !== 4'hF || sat8 !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL sat_final: cnt=%0d sat=%b, required 15 1", cnt8, sat8);
    end
    cycle(8'h40, 8'h02, 1'b1, 1'b1, 1'b0);
    e = sb.pop_front();
    nChecks++;
    if (cnt8 !== 4'h0 || sat8 !== 1'b0 || cq8 !== e.cq || ov8 !== e.ov || any8 !== e.anyBit) begin
      nFail++;
      $display("[TB] FAIL clr_priority: cnt=%0d sat=%b C_q=%h ov=%b any=%b, required 0 0 %h %b %b",
               cnt8, sat8, cq8, ov8, any8, e.cq, e.ov, e.anyBit);
    end
  endtask

  task automatic test_reset_midstream();
    exp_t e;
    cycle(8'h11, 8'h22, 1'b1, 1'b0, 1'b1);
    e = sb.pop_front();
    nChecks++;
    if (cq8 !== e.cq || ov8 !== e.ov || cnt8 !== e.cnt || any8 !== e.anyBit || c8 !== 8'h33) begin
      nFail++;
      $display("[TB] FAIL reset_midstream: C_q=%h ov=%b cnt=%0d any=%b C=%h, required %h %b %0d %b 33",
               cq8, ov8, cnt8, any8, c8, e.cq, e.ov, e.cnt, e.anyBit);
    end
    cycle(8'h80, 8'h08, 1'b1, 1'b0, 1'b0);
    e = sb.pop_front();
    nChecks++;
    if (cq8 !== e.cq || ov8 !== e.ov || cnt8 !== e.cnt) begin
      nFail++;
      $display("[TB] FAIL resume_after_reset: C_q=%h ov=%b cnt=%0d, required %h %b %0d",
               cq8, ov8, cnt8, e.cq, e.ov, e.cnt);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [7:0] a, b;
    logic v, clr;
    for (int i = 0; i < 40; i++) begin
      a   = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
      b   = (i % 3 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      v   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      cycle(a, b, v, clr, 1'b0);
      e = sb.pop_front();
      nChecks++;
      if (cq8 !== e.cq || any8 !== e.anyBit || ov8 !== e.ov || cnt8 !== e.cnt ||
          sat8 !== (e.cnt == 4'hF) || c8 !== (a | b)) begin
        nFail++;
        $display("[TB] FAIL back_to_back_%0d: C_q=%h any=%b ov=%b cnt=%0d sat=%b C=%h, required %h %b %b %0d %b %h",
                 i, cq8, any8, ov8, cnt8, sat8, c8, e.cq, e.anyBit, e.ov, e.cnt,
                 (e.cnt == 4'hF), a | b);
      end
    end
  endtask

  initial begin
    nChecks = 0; nFail = 0;
    mCq = '0; mAny = 1'b0; mOv = 1'b0; mCnt = 0;
    rst = 1'b1;
    a1 = 1'b0; b1 = 1'b0; v1 = 1'b0; clr1 = 1'b0;
    a8 = '0; b8 = '0; v8 = 1'b0; clr8 = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_truth_table();
    test_first_sample();
    test_zero_and_hold();
    test_wide_or();
    test_saturation();
    test_reset_midstream();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/or_gate.md
OR_GATE -- requirements
Module: or_gate

Interface
REQ-001 Parameter WIDTH, default 1, operand width in bits (legal range 1-64).
REQ-002 Parameter CNT_W, default 16, width of the activity counter (legal range 4-32).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 A  input  WIDTH  operand A.
REQ-006 B  input  WIDTH  operand B.
REQ-007 in_valid  input  1  qualifies A/B for the registered path.
REQ-008 clr_cnt  input  1  synchronous clear of the activity counter.
REQ-009 C  output  WIDTH  combinational bitwise OR, A | B.
REQ-010 C_q  output  WIDTH  registered copy of A | B.
REQ-011 out_valid  output  1  C_q holds a result captured on the previous edge.
REQ-012 any_q  output  1  registered reduction OR of the captured result.
REQ-013 act_cnt  output  CNT_W  count of accepted samples with a nonzero result.
REQ-014 cnt_sat  output  1  act_cnt has reached all-ones.

Function
REQ-015 C shall equal A | B bit-for-bit at all times, with no clock dependence and no reset dependence.
REQ-016 C shall settle within the same simulation time step as an A or B change; 1-bit truth table: 00->0, 01->1, 10->1, 11->1.
REQ-017 On a rising edge with rst=0 and in_valid=1, C_q shall load A | B and any_q shall load |(A | B).
REQ-018 On a rising edge with rst=0 and in_valid=0, C_q and any_q shall hold their values.
REQ-019 out_valid shall be a registered copy of in_valid, giving 1-cycle latency; there is no backpressure.
REQ-020 act_cnt shall increment by 1 on each edge where in_valid=1 and (A | B) is nonzero.
REQ-021 act_cnt shall saturate at 2^CNT_W-1 and never wrap.
REQ-022 cnt_sat shall be combinationally high whenever act_cnt is all-ones.
REQ-023 clr_cnt=1 shall set act_cnt to 0 on the next edge and takes priority over increment in the same cycle.
REQ-024 clr_cnt shall not affect C_q, any_q or out_valid.
REQ-025 X or Z on A or B shall propagate per standard OR semantics on C; a 1 on either operand forces 1.

Reset
REQ-026 rst=1 at a rising edge shall force C_q=0, any_q=0, out_valid=0 and act_cnt=0.
REQ-027 rst shall take priority over in_valid and clr_cnt.
REQ-028 C shall remain A | B during reset.
REQ-029 A reset asserted mid-stream shall discard the sample presented in that cycle.
REQ-030 Operation shall resume on the first edge after rst deasserts.

Verification
REQ-031 WIDTH=1, clk running, apply A,B = 00, 01, 10, 11, each held 10 ns and sampled before the next change -> C = 0, 1, 1, 1.
REQ-032 Assert rst for 2 cycles, then drive in_valid=1 with A=0, B=1 -> one edge later C_q=1, any_q=1, out_valid=1, act_cnt=1.
REQ-033 in_valid=1 with A=B=0 -> C_q=0, any_q=0, out_valid=1, act_cnt unchanged; then in_valid=0 with A=1 -> C_q holds 0 and out_valid=0.
REQ-034 CNT_W=4, 20 accepted nonzero samples -> act_cnt stops at 15 with cnt_sat=1; then assert clr_cnt and in_valid with a nonzero sample in the same cycle -> act_cnt=0.
REQ-035 WIDTH=8, A=8'hA0, B=8'h05 -> C=8'hA5 immediately, and C_q=8'hA5 after the edge.
REQ-036 Assert rst in the same cycle as a valid nonzero sample -> C_q=0, out_valid=0, act_cnt=0, while C still equals A | B.
